// File: rtl/acia_rx_fifo.sv
// Asynchronous serial receiver: deglitch filter, frame FSM (5-8 data bits, parity, 1/2 stops)
// and a first-word-fall-through receive FIFO. Break detection is enabled by ACIA_RX_BREAK_EN.
module acia_rx_fifo #(
  parameter int SCW     = 16,
  parameter int DGL     = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_serial,
  input  logic [SCW-1:0]     baud_div,
  input  logic [1:0]         data_bits,
  input  logic               par_en,
  input  logic               par_odd,
  input  logic               stop2,
  input  logic               rd_en,
  output logic [7:0]         rd_dat,
  output logic               rd_perr,
  output logic               rd_ferr,
  output logic               rd_empty,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               rx_stb,
  output logic               ovr,
  input  logic               clr_ovr,
  output logic               brk_stb
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2, S_BRKW
  } state_t;

  state_t             state_q, state_d;
  logic [DGL-1:0]     sh_q, sh_d;
  logic               filt_q, filt_d;
  logic [SCW-1:0]     cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               pbit_q, pbit_d;
  logic [SCW-1:0]     div_q, div_d;
  logic [1:0]         nb_q, nb_d;
  logic               pen_q, pen_d;
  logic               podd_q, podd_d;
  logic               s2_q, s2_d;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]   cntf_q, cntf_d;
  logic               ovr_q, ovr_d;
  logic               rx_stb_q, rx_stb_d;
`ifdef ACIA_RX_BREAK_EN
  logic               brk_q, brk_d;
`endif

  logic               wr_en;
  logic [9:0]         wr_word;
  logic               expire, last_bit;
  logic               f_empty, f_full, do_rd, do_wr, overrun;
  logic [9:0]         head;

  // Input filter: line state only flips after DGL identical samples
  always_comb begin
    sh_d   = {sh_q[DGL-2:0], rx_serial};
    filt_d = filt_q;
    if (&sh_q)
      filt_d = 1'b1;
    else if (~|sh_q)
      filt_d = 1'b0;
  end

  assign expire   = (cnt_q == '0);
  assign last_bit = (bit_q == {1'b1, nb_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    pbit_d  = pbit_q;
    div_d   = div_q;
    nb_d    = nb_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    s2_d    = s2_q;
    wr_en   = 1'b0;
    wr_word = {ferr_q, perr_q, data_q};
`ifdef ACIA_RX_BREAK_EN
    brk_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!filt_q) begin
          div_d   = baud_div;
          nb_d    = data_bits;
          pen_d   = par_en;
          podd_d  = par_odd;
          s2_d    = stop2;
          cnt_d   = baud_div >> 1;
          bit_d   = 3'd0;
          data_d  = 8'h00;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          pbit_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (expire) begin
          cnt_d   = div_q;
          state_d = filt_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_DATA: begin
        if (expire) begin
          cnt_d         = div_q;
          data_d[bit_q] = filt_q;
          bit_d         = bit_q + 3'd1;
          if (last_bit)
            state_d = pen_q ? S_PAR : S_STOP1;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_PAR: begin
        if (expire) begin
          cnt_d   = div_q;
          pbit_d  = filt_q;
          perr_d  = (^data_q) ^ filt_q ^ podd_q;
          state_d = S_STOP1;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_STOP1: begin
        if (expire) begin
          cnt_d = div_q;
`ifdef ACIA_RX_BREAK_EN
          if (!filt_q && (data_q == 8'h00) && !pbit_q) begin
            brk_d   = 1'b1;
            state_d = S_BRKW;
          end else
`endif
          if (s2_q) begin
            ferr_d  = ~filt_q;
            state_d = S_STOP2;
          end else begin
            wr_en   = 1'b1;
            wr_word = {~filt_q, perr_q, data_q};
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_STOP2: begin
        if (expire) begin
          wr_en   = 1'b1;
          wr_word = {ferr_q | ~filt_q, perr_q, data_q};
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_BRKW: begin
        if (filt_q)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a write into a full FIFO is still accepted when the head is popped in the same cycle
  assign f_empty = (cntf_q == '0);
  assign f_full  = (cntf_q == FULL_CNT);
  assign do_rd   = rd_en & ~f_empty;
  assign do_wr   = wr_en & (~f_full | do_rd);
  assign overrun = wr_en & f_full & ~do_rd;

  always_comb begin
    wp_d     = do_wr ? wp_q + FIFO_AW'(1) : wp_q;
    rp_d     = do_rd ? rp_q + FIFO_AW'(1) : rp_q;
    cntf_d   = cntf_q;
    if (do_wr && !do_rd)
      cntf_d = cntf_q + (FIFO_AW+1)'(1);
    else if (do_rd && !do_wr)
      cntf_d = cntf_q - (FIFO_AW+1)'(1);
    ovr_d    = (ovr_q & ~clr_ovr) | overrun;
    rx_stb_d = do_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      wp_q     <= '0;
      rp_q     <= '0;
      cntf_q   <= '0;
      ovr_q    <= 1'b0;
      rx_stb_q <= 1'b0;
`ifdef ACIA_RX_BREAK_EN
      brk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cntf_q   <= cntf_d;
      ovr_q    <= ovr_d;
      rx_stb_q <= rx_stb_d;
`ifdef ACIA_RX_BREAK_EN
      brk_q    <= brk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    perr_q <= perr_d;
    ferr_q <= ferr_d;
    pbit_q <= pbit_d;
    div_q  <= div_d;
    nb_q   <= nb_d;
    pen_q  <= pen_d;
    podd_q <= podd_d;
    s2_q   <= s2_d;
    if (do_wr)
      mem_q[wp_q] <= wr_word;
  end

  assign head     = mem_q[rp_q];
  assign rd_empty = f_empty;
  assign rd_dat   = f_empty ? 8'h00 : head[7:0];
  assign rd_perr  = ~f_empty & head[8];
  assign rd_ferr  = ~f_empty & head[9];
  assign fifo_cnt = cntf_q;
  assign rx_stb   = rx_stb_q;
  assign ovr      = ovr_q;
`ifdef ACIA_RX_BREAK_EN
  assign brk_stb  = brk_q;
`else
  assign brk_stb  = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Bench for acia_rx_fifo: directed frames plus randomized frames checked against a queue model.
module tb_acia_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        par_en, par_odd, stop2;
  logic        rd_en;
  logic [7:0]  rd_dat;
  logic        rd_perr, rd_ferr, rd_empty;
  logic [2:0]  fifo_cnt;
  logic        rx_stb, ovr, clr_ovr, brk_stb;

  always #5 clk = ~clk;

  acia_rx_fifo #(.SCW(16), .DGL(8), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .baud_div(baud_div),
    .data_bits(data_bits), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
    .rd_en(rd_en), .rd_dat(rd_dat), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
    .rd_empty(rd_empty), .fifo_cnt(fifo_cnt), .rx_stb(rx_stb), .ovr(ovr),
    .clr_ovr(clr_ovr), .brk_stb(brk_stb)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  ent_t q[$];
  bit   ovr_exp = 1'b0;
  int   n_chk = 0, n_err = 0;
  int   stb_cnt = 0, brk_cnt = 0;

  always @(negedge clk) begin
    if (rx_stb) stb_cnt++;
    if (brk_stb) brk_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int len);
    rx_serial = v;
    repeat (len) @(negedge clk);
  endtask

  // A low stop bit is held just past the sampling point so the line is high again
  // before a spurious restart could pass its start-bit check.
  task automatic drive_stop(input logic v, input int per);
    if (v) drive_bit(1'b1, per);
    else begin
      drive_bit(1'b0, per / 2 + 4);
      drive_bit(1'b1, per - per / 2 - 4);
    end
  endtask

  task automatic model_push(input ent_t e);
    if (q.size() < 4) q.push_back(e);
    else ovr_exp = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                            input bit s2, input bit bad_par, input bit s2v, input int div);
    int         per;
    logic [7:0] md;
    logic       pb;
    ent_t       e;
    per       = div + 1;
    md        = d & 8'((1 << nb) - 1);
    pb        = (^md) ^ podd ^ bad_par;
    baud_div  = 16'(div);
    data_bits = 2'(nb - 5);
    par_en    = pen;
    par_odd   = podd;
    stop2     = s2;
    drive_bit(1'b0, per);
    for (int i = 0; i < nb; i++) drive_bit(md[i], per);
    if (pen) drive_bit(pb, per);
    drive_stop(1'b1, per);
    if (s2) drive_stop(s2v, per);
    drive_bit(1'b1, 3 * per);
    e.d  = md;
    e.pe = pen ? ((^md) ^ pb ^ podd) : 1'b0;
    e.fe = s2 & ~s2v;
    model_push(e);
  endtask

  task automatic read_check(input string tag);
    ent_t e;
    chk({tag, "_empty"}, rd_empty, 0);
    if (q.size() == 0) begin
      chk({tag, "_model_nonempty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_dat"}, rd_dat, e.d);
    chk({tag, "_perr"}, rd_perr, e.pe);
    chk({tag, "_ferr"}, rd_ferr, e.fe);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int s0, b0, per, nf;
    rst = 1'b1; rx_serial = 1'b1; baud_div = 16'd138; data_bits = 2'd3;
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_empty", rd_empty, 1);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_stb", rx_stb, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_brk", brk_stb, 0);
    chk("rst_dat", {rd_ferr, rd_perr, rd_dat}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 single byte
    s0 = stb_cnt;
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 138);
    chk("a5_stb", stb_cnt - s0, 1);
    chk("a5_cnt", fifo_cnt, 1);
    read_check("a5");
    chk("a5_empty_after", rd_empty, 1);

    // 7E1 bad then good parity
    send_frame(8'h41, 7, 1, 0, 0, 1, 1, 138);
    read_check("7e1_bad");
    send_frame(8'h41, 7, 1, 0, 0, 0, 1, 138);
    read_check("7e1_good");

    // 8N2 with low second stop bit, then an idle-line glitch
    send_frame(8'h55, 8, 0, 0, 1, 0, 0, 138);
    read_check("8n2_ferr");
    s0 = stb_cnt;
    drive_bit(1'b0, 60);
    drive_bit(1'b1, 300);
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 100);
    chk("glitch_stb", stb_cnt - s0, 0);
    chk("glitch_cnt", fifo_cnt, 0);
    send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 138);
    read_check("after_glitch");

    // Overrun with a 4-deep FIFO
    s0 = stb_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 0, 0, 1, 40);
    chk("ovr_cnt", fifo_cnt, 4);
    chk("ovr_flag", ovr, ovr_exp);
    chk("ovr_stb", stb_cnt - s0, 4);
    for (int i = 0; i < 4; i++) read_check("ovr_rd");
    chk("ovr_still", ovr, 1);
    clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
    ovr_exp = 1'b0;
    chk("ovr_clr", ovr, ovr_exp);

    // Break: line low for 12 bit times
    per = 41;
    baud_div = 16'd40; data_bits = 2'd3; par_en = 1'b0; stop2 = 1'b0;
    b0 = brk_cnt;
    drive_bit(1'b0, 12 * per);
    drive_bit(1'b1, 14 * per);
`ifdef ACIA_RX_BREAK_EN
    chk("brk_pulses", brk_cnt - b0, 1);
    chk("brk_cnt", fifo_cnt, 0);
`else
    chk("brk_none", brk_cnt - b0, 0);
    chk("brk_dat", rd_dat, 8'h00);
    chk("brk_ferr", rd_ferr, 1);
    chk("brk_perr", rd_perr, 0);
    for (int i = 0; i < 8; i++) begin
      if (!rd_empty) begin
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
      end
    end
    chk("brk_flushed", rd_empty, 1);
`endif
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 40);
    read_check("after_brk");

    // Reset in the middle of a frame
    s0 = stb_cnt;
    drive_bit(1'b0, per);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, per);
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    drive_bit(1'b1, 15 * per);
    chk("rstmid_cnt", fifo_cnt, 0);
    chk("rstmid_empty", rd_empty, 1);
    chk("rstmid_stb", stb_cnt - s0, 0);
    send_frame(8'h7E, 8, 0, 0, 0, 0, 1, 40);
    read_check("after_rst");

    // Randomized frames against the queue model
    for (int r = 0; r < 8; r++) begin
      nf = $urandom_range(1, 3);
      s0 = stb_cnt;
      for (int k = 0; k < nf; k++) begin
        int  div, nb;
        bit  pen, podd, s2, bad, s2v;
        div  = $urandom_range(15, 40);
        nb   = $urandom_range(5, 8);
        pen  = 1'($urandom_range(0, 1));
        podd = 1'($urandom_range(0, 1));
        s2   = 1'($urandom_range(0, 1));
        bad  = 1'($urandom_range(0, 1));
        s2v  = ($urandom_range(0, 3) != 0);
        send_frame(8'($urandom), nb, pen, podd, s2, bad, s2v, div);
      end
      chk("rnd_stb", stb_cnt - s0, nf);
      chk("rnd_cnt", fifo_cnt, q.size());
      while (q.size() > 0) read_check("rnd");
      chk("rnd_empty", rd_empty, 1);
    end
    chk("final_ovr", ovr, ovr_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
